fifo_buffer: RTL
================

FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2; almost_full asserted when count >= AFULL_LVL.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2; almost_empty asserted when count <= AEMPTY_LVL.
REQ-005 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_L  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents.
REQ-008 SHALL have port we  input  1  write request.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port re  input  1  read request.
REQ-011 SHALL have port rdata  output  WIDTH  registered read data.
REQ-012 SHALL have port rvalid  output  1  rdata valid, one-cycle pulse per accepted read.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.
REQ-016 SHALL have port err_clear  input  1  synchronous clear of overflow/underflow.

Function
REQ-017 Write accepted when we && (!full || read accepted same cycle); wdata stored at write pointer.
REQ-018 Read accepted when re && !empty; no write-to-read bypass when empty.
REQ-019 Accepted read: rdata <= oldest entry and rvalid <= 1 on the same edge (latency 1 cycle); otherwise rvalid <= 0 and rdata holds.
REQ-020 Pointers are $clog2(DEPTH) bits, increment by 1 per accepted operation, wrap DEPTH-1 -> 0.
REQ-021 count +1 on write only, -1 on read only, unchanged on both or neither.
REQ-022 full = (count == DEPTH), empty = (count == 0); all flags combinational from registered count.
REQ-023 Simultaneous read+write when full: both accepted, count stays DEPTH.
REQ-024 Simultaneous read+write when empty: write accepted, read rejected, count becomes 1, rvalid 0.
REQ-025 flush has priority over we/re: pointers 0, count 0, rvalid 0 next edge; memory contents and rdata unchanged.
REQ-026 Data order strictly first-in first-out across any number of pointer wraps.

Reset
REQ-027 reset_L low SHALL immediately force pointers 0, count 0, rvalid 0, rdata 0, overflow 0, underflow 0.
REQ-028 Reset mid-operation discards all stored entries; memory array itself is not reset.
REQ-029 Outputs after reset: empty 1, almost_empty 1, full 0, almost_full 0 (for AFULL_LVL > 0).

Configuration
REQ-030 Macro FIFO_BUFFER_ERR_EN defined: overflow sets on we && !accepted, underflow sets on re && empty; both sticky until err_clear or reset; set wins over err_clear same cycle.
REQ-031 FIFO_BUFFER_ERR_EN undefined: overflow and underflow tied 0, err_clear ignored; ports remain present.

Verification
REQ-032 Reset, write 0x11..0x20 (16 words) -> full=1, count=16, almost_full from count 14; read 16 -> 0x11..0x20 in order, rvalid each cycle after re.
REQ-033 Full, we=1 re=1 wdata=0xAA -> rdata=oldest, count stays 16; after draining, 0xAA read last.
REQ-034 Empty, we=1 re=1 wdata=0x55 -> rvalid=0, count=1; next read returns 0x55.
REQ-035 Write 40 words with interleaved reads (count kept 3..10) -> all 40 returned in order across pointer wraps.
REQ-036 Count 5, flush=1 with we=1 -> count=0, empty=1, written word discarded.
REQ-037 FIFO_BUFFER_ERR_EN defined: we when full -> overflow=1 held; re when empty -> underflow=1; err_clear -> both 0; undefined: both stay 0.

Source files
------------

// File: rtl/fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_buffer
// Summary  : Single-clock FIFO with a registered read port and level flags.
//            Optional sticky overflow/underflow flags are built in only when
//            the macro FIFO_BUFFER_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_buffer #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int AFULL_LVL  = DEPTH - 2,
   parameter int AEMPTY_LVL = 2
) (
   input  logic                   clock,
   input  logic                   reset_L,
   input  logic                   flush,
   input  logic                   we,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   re,
   output logic [WIDTH-1:0]       rdata,
   output logic                   rvalid,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   err_clear
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LVL);
   localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LVL);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;
   logic             w_rd_acc;
   logic             w_wr_acc;

   // A full FIFO still accepts a write when a read frees a slot on the same edge
   assign w_rd_acc = re && (count_q != '0);
   assign w_wr_acc = we && ((count_q != FULL_CNT) || w_rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rdata_d  = mem_q[rd_ptr_q];
            rvalid_d = 1'b1;
         end
         if (w_wr_acc && !w_rd_acc) begin
            count_d = count_q + CW'(1);
         end else if (!w_wr_acc && w_rd_acc) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Storage is deliberately left out of reset; the pointers define validity
   always_ff @(posedge clock) begin
      if (w_wr_acc && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata        = rdata_q;
   assign rvalid       = rvalid_q;
   assign count        = count_q;
   assign full         = (count_q == FULL_CNT);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFULL_CNT);
   assign almost_empty = (count_q <= AEMPTY_CNT);

`ifdef FIFO_BUFFER_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // A new error event wins over err_clear on the same edge
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (we && !w_wr_acc) begin
         ovf_d = 1'b1;
      end else if (err_clear) begin
         ovf_d = 1'b0;
      end
      if (re && (count_q == '0)) begin
         udf_d = 1'b1;
      end else if (err_clear) begin
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = udf_q;
`else
   logic unused_err_clear;
   assign unused_err_clear = err_clear;
   assign overflow         = 1'b0;
   assign underflow        = 1'b0;
`endif

endmodule
`default_nettype wire
